ysyx_23060236_axi_burst_rom: RTL and testbench

AXI4-style read-only burst responder that serves instruction-fetch cache-line refills. It accepts one AR request at a time and returns arlen+1 beats on R with per-beat rresp and rlast. Read data comes from an internal word array that a side write port preloads. The block is the memory-side partner of the IFU refill master in simulation/SoC builds and models a configurable first-beat latency.

---
 rtl/ysyx_23060236_axi_burst_rom.sv | 186 ++++++++++++++++++
 tb/tb_ysyx_23060236_axi_burst_rom.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060236_axi_burst_rom.sv
// Read-only AXI4-style burst responder for I-fetch line refills, with a preloadable word array.
// First beat LATENCY+1 cycles after AR; then 1 beat/cycle. R beats hold while rready=0; arready=0 outside IDLE.
module ysyx_23060236_axi_burst_rom #(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int          DEPTH_LOG2 = 10,
  parameter int          LATENCY    = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [31:0]           araddr,
  input  logic                  arvalid,
  output logic                  arready,
  input  logic [1:0]            arburst,
  input  logic [3:0]            arlen,
  output logic [31:0]           rdata,
  output logic [1:0]            rresp,
  output logic                  rlast,
  output logic                  rvalid,
  input  logic                  rready,
  input  logic                  mem_wen,
  input  logic [DEPTH_LOG2-1:0] mem_waddr,
  input  logic [31:0]           mem_wdata
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST} state_t;

  localparam logic [32:0] REGION_END = {1'b0, BASE_ADDR} + (33'd1 << (DEPTH_LOG2 + 2));

  state_t      r_state;
  logic [31:0] r_addr;
  logic [3:0]  r_len;
  logic [1:0]  r_burst;
  logic [3:0]  r_beat;
  logic [3:0]  r_dly;
  logic        r_arready;
  logic        r_rvalid;
  logic        r_rlast;
  logic [1:0]  r_rresp;
  logic [31:0] r_rdata;

  logic [31:0] r_mem [2**DEPTH_LOG2];

  always_ff @(posedge clock) begin
    if (mem_wen) r_mem[mem_waddr] <= mem_wdata;
  end

  logic [31:0]           w_inc;
  logic [31:0]           w_wmask;
  logic [31:0]           w_next_addr;
  logic [31:0]           w_ld_addr;
  logic [1:0]            w_ld_burst;
  logic [3:0]            w_ld_len;
  logic [3:0]            w_ld_beat;
  logic                  w_wrap_ok;
  logic                  w_slverr;
  logic                  w_in_range;
  logic [31:0]           w_off;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic [1:0]            w_ld_resp;
  logic [31:0]           w_ld_data;
  logic                  w_ld_last;

  // WRAP span for legal lengths is (len+1)*4 bytes, so the in-span mask is {len,2'b11}.
  assign w_inc   = r_addr + 32'd4;
  assign w_wmask = {26'd0, r_len, 2'b11};

  always_comb begin
    w_next_addr = w_inc;
    case (r_burst)
      2'b00:   w_next_addr = r_addr;
      2'b10:   w_next_addr = (r_addr & ~w_wmask) | (w_inc & w_wmask);
      default: w_next_addr = w_inc;
    endcase
  end

  // Selects which beat gets loaded into the R registers at the next edge.
  always_comb begin
    w_ld_addr  = w_next_addr;
    w_ld_burst = r_burst;
    w_ld_len   = r_len;
    w_ld_beat  = r_beat + 4'd1;
    case (r_state)
      S_IDLE: begin
        w_ld_addr  = araddr & 32'hFFFF_FFFC;
        w_ld_burst = arburst;
        w_ld_len   = arlen;
        w_ld_beat  = 4'd0;
      end
      S_WAIT: begin
        w_ld_addr  = r_addr;
        w_ld_beat  = 4'd0;
      end
      default: ;
    endcase
  end

  assign w_wrap_ok  = (w_ld_len == 4'd1) || (w_ld_len == 4'd3) ||
                      (w_ld_len == 4'd7) || (w_ld_len == 4'd15);
  assign w_slverr   = (w_ld_burst == 2'b11) || ((w_ld_burst == 2'b10) && !w_wrap_ok);
  assign w_in_range = ({1'b0, w_ld_addr} >= {1'b0, BASE_ADDR}) && ({1'b0, w_ld_addr} < REGION_END);
  assign w_off      = w_ld_addr - BASE_ADDR;
  assign w_idx      = DEPTH_LOG2'(w_off >> 2);
  assign w_ld_last  = (w_ld_beat == w_ld_len);

  always_comb begin
    w_ld_resp = 2'b00;
    w_ld_data = 32'd0;
    if (w_slverr)        w_ld_resp = 2'b10;
    else if (!w_in_range) w_ld_resp = 2'b11;
    else                 w_ld_data = r_mem[w_idx];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_addr    <= 32'd0;
      r_len     <= 4'd0;
      r_burst   <= 2'b00;
      r_beat    <= 4'd0;
      r_dly     <= 4'd0;
      r_arready <= 1'b1;
      r_rvalid  <= 1'b0;
      r_rlast   <= 1'b0;
      r_rresp   <= 2'b00;
      r_rdata   <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (arvalid) begin
            r_addr    <= w_ld_addr;
            r_len     <= arlen;
            r_burst   <= arburst;
            r_beat    <= 4'd0;
            r_arready <= 1'b0;
            if (LATENCY == 0) begin
              r_state  <= S_BURST;
              r_rvalid <= 1'b1;
              r_rdata  <= w_ld_data;
              r_rresp  <= w_ld_resp;
              r_rlast  <= w_ld_last;
            end else begin
              // WAIT holds LATENCY cycles; the beat loads on the edge leaving it.
              r_state <= S_WAIT;
              r_dly   <= 4'(LATENCY - 1);
            end
          end
        end
        S_WAIT: begin
          if (r_dly == 4'd0) begin
            r_state  <= S_BURST;
            r_rvalid <= 1'b1;
            r_rdata  <= w_ld_data;
            r_rresp  <= w_ld_resp;
            r_rlast  <= w_ld_last;
          end else begin
            r_dly <= r_dly - 4'd1;
          end
        end
        S_BURST: begin
          if (rready) begin
            if (r_beat == r_len) begin
              r_state   <= S_IDLE;
              r_rvalid  <= 1'b0;
              r_rlast   <= 1'b0;
              r_arready <= 1'b1;
            end else begin
              r_beat  <= w_ld_beat;
              r_addr  <= w_next_addr;
              r_rdata <= w_ld_data;
              r_rresp <= w_ld_resp;
              r_rlast <= w_ld_last;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign arready = r_arready;
  assign rvalid  = r_rvalid;
  assign rlast   = r_rlast;
  assign rresp   = r_rresp;
  assign rdata   = r_rdata;

endmodule

// File: tb/tb_ysyx_23060236_axi_burst_rom.sv
// Bench for the burst ROM: directed refill bursts plus random bursts against an address-sequence model.
module tb_ysyx_23060236_axi_burst_rom;

  localparam logic [31:0] BASE  = 32'h3000_0000;
  localparam int          DLOG  = 10;
  localparam int          DEPTH = 1 << DLOG;
  localparam int          LAT   = 2;

  logic            clock = 1'b0;
  logic            reset;
  logic [31:0]     araddr;
  logic            arvalid;
  logic            arready;
  logic [1:0]      arburst;
  logic [3:0]      arlen;
  logic [31:0]     rdata;
  logic [1:0]      rresp;
  logic            rlast;
  logic            rvalid;
  logic            rready;
  logic            mem_wen;
  logic [DLOG-1:0] mem_waddr;
  logic [31:0]     mem_wdata;

  logic [31:0] shadow [DEPTH];
  int n_checks = 0;
  int n_fail   = 0;

  ysyx_23060236_axi_burst_rom #(.BASE_ADDR(BASE), .DEPTH_LOG2(DLOG), .LATENCY(LAT)) dut (
    .clock(clock), .reset(reset),
    .araddr(araddr), .arvalid(arvalid), .arready(arready), .arburst(arburst), .arlen(arlen),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expected beat i of a burst, from the address-sequence rules.
  task automatic exp_beat(input logic [31:0] start, input logic [1:0] b, input logic [3:0] l,
                          input int i, output logic [31:0] d, output logic [1:0] r,
                          output logic la, output int idx);
    longint unsigned s, a, span, lo;
    bit slv;
    s = longint'(start & 32'hFFFF_FFFC);
    span = longint'((int'(l) + 1) * 4);
    case (b)
      2'b00: a = s;
      2'b10: begin
        lo = s - (s % span);
        a  = lo + ((s - lo + longint'(4 * i)) % span);
      end
      default: a = (s + longint'(4 * i)) % 64'h1_0000_0000;
    endcase
    slv = (b == 2'b11) || (b == 2'b10 && !(l == 1 || l == 3 || l == 7 || l == 15));
    idx = -1;
    d   = 32'd0;
    if (slv) r = 2'b10;
    else if (a >= longint'(BASE) && a < longint'(BASE) + longint'(4 * DEPTH)) begin
      r   = 2'b00;
      idx = int'((a - longint'(BASE)) / 4);
      d   = shadow[idx];
    end else r = 2'b11;
    la = (i == int'(l));
  endtask

  task automatic preload(input int idx, input logic [31:0] val);
    mem_wen   = 1'b1;
    mem_waddr = DLOG'(idx);
    mem_wdata = val;
    shadow[idx] = val;
    @(negedge clock);
    mem_wen = 1'b0;
  endtask

  // Starts and ends at a negedge. mode: 0 rready=1, 1 pattern 1,0,0, 2 random.
  task automatic run_burst(input logic [31:0] a, input logic [1:0] b, input logic [3:0] l,
                           input int mode, input int abort_at, input bit keep_ar, input bit poke);
    int k, cyc, step, idx;
    bit fresh, poked, rr;
    logic [31:0] ed;
    logic [1:0]  er;
    logic        el;
    araddr = a; arburst = b; arlen = l; arvalid = 1'b1; rready = 1'b0;
    check_eq("ar_ready_idle", arready, 1'b1);
    @(negedge clock);
    if (!keep_ar) arvalid = 1'b0;
    check_eq("ar_ready_busy", arready, 1'b0);
    cyc = 1;
    while (!rvalid && cyc < 40) begin
      @(negedge clock);
      cyc++;
    end
    check_eq("first_latency", cyc, LAT + 1);
    if (!rvalid) return;
    k = 0; step = 0; fresh = 1'b1; poked = 1'b0;
    ed = 0; er = 0; el = 0; idx = -1;
    while (k <= int'(l) && step < 400) begin
      if (fresh) begin
        exp_beat(a, b, l, k, ed, er, el, idx);
        fresh = 1'b0;
        if (abort_at == k) begin
          reset = 1'b1; rready = 1'b0;
          @(negedge clock);
          check_eq("abort_rvalid", rvalid, 1'b0);
          check_eq("abort_arready", arready, 1'b1);
          check_eq("abort_rlast", rlast, 1'b0);
          check_eq("abort_rresp", rresp, 2'b00);
          check_eq("abort_rdata", rdata, 32'd0);
          reset = 1'b0; arvalid = 1'b0;
          @(negedge clock);
          check_eq("abort_no_beat", rvalid, 1'b0);
          return;
        end
      end
      check_eq("beat_rvalid", rvalid, 1'b1);
      check_eq("beat_rdata", rdata, ed);
      check_eq("beat_rresp", rresp, er);
      check_eq("beat_rlast", rlast, el);
      check_eq("beat_arready", arready, 1'b0);
      case (mode)
        0:       rr = 1'b1;
        1:       rr = (step % 3 == 0);
        default: rr = 1'($urandom_range(0, 1));
      endcase
      // Overwrite the held beat's word: this beat must keep its old data.
      if (!rr && poke && !poked && idx >= 0) begin
        mem_wen = 1'b1; mem_waddr = DLOG'(idx); mem_wdata = ~ed;
        shadow[idx] = ~ed;
        poked = 1'b1;
      end
      rready = rr;
      @(negedge clock);
      mem_wen = 1'b0;
      step++;
      if (rr) begin
        k++;
        fresh = 1'b1;
      end
    end
    check_eq("beat_count", k, int'(l) + 1);
    rready = 1'b0;
    check_eq("end_rvalid", rvalid, 1'b0);
    check_eq("end_arready", arready, 1'b1);
    check_eq("end_rlast", rlast, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra;
    logic [1:0]  rb;
    reset = 1'b1; arvalid = 1'b0; araddr = 0; arburst = 0; arlen = 0; rready = 1'b0;
    mem_wen = 1'b0; mem_waddr = 0; mem_wdata = 0;
    repeat (3) @(negedge clock);
    check_eq("rst_arready", arready, 1'b1);
    check_eq("rst_rvalid", rvalid, 1'b0);
    check_eq("rst_rlast", rlast, 1'b0);
    check_eq("rst_rresp", rresp, 2'b00);
    check_eq("rst_rdata", rdata, 32'd0);
    reset = 1'b0;
    @(negedge clock);

    for (int i = 0; i < DEPTH; i++) preload(i, (i < 8) ? 32'h1000 + i : $urandom);

    run_burst(BASE, 2'b01, 4'd7, 0, -1, 1'b0, 1'b0);
    run_burst(BASE, 2'b01, 4'd7, 1, -1, 1'b0, 1'b0);
    run_burst(BASE + 32'hC, 2'b10, 4'd3, 0, -1, 1'b0, 1'b0);
    run_burst(BASE + 32'hC, 2'b10, 4'd2, 0, -1, 1'b0, 1'b0);
    run_burst(BASE + 4 * (DEPTH - 1), 2'b01, 4'd3, 0, -1, 1'b0, 1'b0);
    run_burst(BASE, 2'b11, 4'd0, 0, -1, 1'b0, 1'b0);
    run_burst(BASE + 32'h40, 2'b00, 4'd3, 1, -1, 1'b0, 1'b1);
    run_burst(BASE + 32'h40, 2'b01, 4'd1, 0, -1, 1'b0, 1'b0);
    run_burst(BASE, 2'b01, 4'd7, 0, 4, 1'b0, 1'b0);
    run_burst(BASE + 32'h20, 2'b01, 4'd7, 0, -1, 1'b0, 1'b0);
    run_burst(BASE + 32'h100, 2'b01, 4'd1, 0, -1, 1'b1, 1'b0);
    run_burst(BASE + 32'h100, 2'b01, 4'd1, 0, -1, 1'b0, 1'b0);

    for (int n = 0; n < 30; n++) begin
      case ($urandom_range(0, 3))
        0:       ra = BASE + 4 * $urandom_range(0, DEPTH - 1);
        1:       ra = BASE + 4 * $urandom_range(DEPTH - 8, DEPTH - 1);
        2:       ra = BASE - 4 * $urandom_range(1, 4);
        default: ra = $urandom;
      endcase
      ra = ra | 32'($urandom_range(0, 3));
      rb = 2'($urandom_range(0, 3));
      run_burst(ra, rb, 4'($urandom_range(0, 15)), 2, -1, 1'b0, 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
